// File: rtl/multicycle_control.sv
// multicycle_control: Moore controller for a multicycle MIPS-style datapath.
// Sequences fetch, decode, load/store, R-type, beq, j and addi.
module multicycle_control #(
   parameter int          PC_W     = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          ADDI_EN  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   input  logic            mem_ready,
   input  logic            alu_zero,
   output logic            mem_req,
   output logic            mem_we,
   output logic            iord,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     ir,
   output logic            reg_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [3:0]      state,
   output logic            illegal,
   output logic [31:0]     retired
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // pc bits below 28 are replaced by a jump; the rest are kept
   localparam logic [PC_W-1:0] LO_MASK = PC_W'(32'h0FFF_FFFF);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic [31:0]     retired_q, retired_d;
   logic [5:0]      opc;
   logic [31:0]     br_off;
   logic [31:0]     j_tgt;
   logic            op_legal;

   assign opc    = ir_q[31:26];
   assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
   assign j_tgt  = {4'b0000, ir_q[25:0], 2'b00};

   // opcodes this build knows how to execute
   always_comb begin
      op_legal = 1'b0;
      case (opc)
         OP_R, OP_J, OP_BEQ, OP_LW, OP_SW: op_legal = 1'b1;
         OP_ADDI: op_legal = (ADDI_EN != 0);
         default: op_legal = 1'b0;
      endcase
   end

   // next state, pc, ir and retire count
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = instr;
               pc_d    = pc_q + PC_W'(4);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!op_legal) begin
               state_d = S_FETCH;
            end else begin
               case (opc)
                  OP_R:    state_d = S_EXEC;
                  OP_LW,
                  OP_SW:   state_d = S_MEM_ADDR;
                  OP_BEQ:  state_d = S_BRANCH;
                  OP_J:    state_d = S_JUMP;
                  default: state_d = S_ADDI_EX;
               endcase
            end
         end
         S_MEM_ADDR: begin
            state_d = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d   = S_FETCH;
               retired_d = retired_q + 32'd1;
            end
         end
         S_EXEC: state_d = S_R_WB;
         S_R_WB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
         end
         S_BRANCH: begin
            if (alu_zero) pc_d = pc_q + br_off[PC_W-1:0];
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
         end
         S_JUMP: begin
            pc_d      = (pc_q & ~LO_MASK) | j_tgt[PC_W-1:0];
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
         end
         S_ADDI_EX: state_d = S_ADDI_WB;
         S_ADDI_WB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC[PC_W-1:0];
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Moore control decode; reset silences everything, so a transfer
   // aborts at once and restarts only from the FETCH decode
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: mem_req = 1'b1;
            S_DECODE: illegal = !op_legal;
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b01;
            end
            S_ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default: ;
         endcase
      end
   end

   assign pc      = pc_q;
   assign ir      = ir_q;
   assign retired = retired_q;
   assign state   = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; two controllers execute small
// programs and every completed instruction is checked against a queue.
module tb_multicycle_control;

   typedef struct packed {
      logic [31:0] path;
      logic [31:0] pc;
      logic [31:0] ret;
      logic [31:0] d;
      logic [31:0] w;
      logic [31:0] ill;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic [31:0] instr_a, instr_b;
   logic        ready_a = 1'b1, ready_b = 1'b1;
   logic        zero_a = 1'b0, zero_b = 1'b0;
   logic        mem_req_a, mem_we_a, iord_a;
   logic        mem_req_b, mem_we_b, iord_b;
   logic [31:0] pc_a;
   logic [7:0]  pc_b;
   logic [31:0] ir_a, ir_b;
   logic        rw_a, rd_a, m2r_a, sa_a;
   logic        rw_b, rd_b, m2r_b, sa_b;
   logic [1:0]  sb_a, op_a, sb_b, op_b;
   logic [3:0]  state_a, state_b;
   logic        illegal_a, illegal_b;
   logic [31:0] retired_a, retired_b;

   logic [31:0] imem_a [0:127];
   logic [31:0] imem_b [0:63];
   assign instr_a = imem_a[pc_a[8:2]];
   assign instr_b = imem_b[pc_b[7:2]];

   multicycle_control dut_a (
      .clk(clk), .rst(rst_a), .instr(instr_a),
      .mem_ready(ready_a), .alu_zero(zero_a),
      .mem_req(mem_req_a), .mem_we(mem_we_a), .iord(iord_a),
      .pc(pc_a), .ir(ir_a), .reg_write(rw_a), .reg_dst(rd_a),
      .mem_to_reg(m2r_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
      .alu_op(op_a), .state(state_a), .illegal(illegal_a),
      .retired(retired_a)
   );

   multicycle_control #(
      .PC_W(8), .RESET_PC(32'h40), .ADDI_EN(0)
   ) dut_b (
      .clk(clk), .rst(rst_b), .instr(instr_b),
      .mem_ready(ready_b), .alu_zero(zero_b),
      .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b),
      .pc(pc_b), .ir(ir_b), .reg_write(rw_b), .reg_dst(rd_b),
      .mem_to_reg(m2r_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
      .alu_op(op_b), .state(state_b), .illegal(illegal_b),
      .retired(retired_b)
   );

   int n_chk = 0;
   int n_fail = 0;
   rec_t q_a[$];
   rec_t q_b[$];

   logic [31:0] m_path [2];
   logic [3:0]  m_prev [2];
   logic [31:0] m_d [2];
   logic [31:0] m_w [2];
   logic [31:0] m_ill [2];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [31:0] path,
                       input logic [31:0] pcv, input logic [31:0] ret,
                       input logic [31:0] d, input logic [31:0] w,
                       input logic [31:0] ill);
      rec_t r;
      r = '{path: path, pc: pcv, ret: ret, d: d, w: w, ill: ill};
      if (id == 0) q_a.push_back(r);
      else q_b.push_back(r);
   endtask

   // monitor: one call per negedge per DUT; compares at each return to FETCH
   task automatic observe(input int id, input logic r,
                          input logic [3:0] st, input logic [31:0] pcv,
                          input logic [31:0] retv, input logic req,
                          input logic we, input logic io, input logic il);
      rec_t e;
      int   qs;
      if (r) begin
         m_path[id] = '0;
         m_prev[id] = '0;
         m_d[id]    = '0;
         m_w[id]    = '0;
         m_ill[id]  = '0;
         return;
      end
      if (req && io) m_d[id] = m_d[id] + 1;
      if (req && we) m_w[id] = m_w[id] + 1;
      if (il) m_ill[id] = m_ill[id] + 1;
      if (st != m_prev[id]) m_path[id] = {m_path[id][27:0], st};
      if (st == 4'd0 && m_prev[id] != 4'd0) begin
         qs = (id == 0) ? q_a.size() : q_b.size();
         if (qs == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d retire: unexpected, got pc %h expected none",
                     id, pcv);
         end else begin
            if (id == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            check($sformatf("dut%0d path", id), m_path[id], e.path);
            check($sformatf("dut%0d pc", id), pcv, e.pc);
            check($sformatf("dut%0d retired", id), retv, e.ret);
            check($sformatf("dut%0d data cycles", id), m_d[id], e.d);
            check($sformatf("dut%0d write cycles", id), m_w[id], e.w);
            check($sformatf("dut%0d illegal pulses", id), m_ill[id], e.ill);
         end
         m_path[id] = '0;
         m_d[id]    = '0;
         m_w[id]    = '0;
         m_ill[id]  = '0;
      end
      m_prev[id] = st;
   endtask

   always @(negedge clk)
      observe(0, rst_a, state_a, pc_a, retired_a,
              mem_req_a, mem_we_a, iord_a, illegal_a);

   always @(negedge clk)
      observe(1, rst_b, state_b, {24'h0, pc_b}, retired_b,
              mem_req_b, mem_we_b, iord_b, illegal_b);

   // alu_zero for DUT A per BRANCH visit: taken, taken, not taken
   logic [2:0] zpat = 3'b011;
   int nbr = 0;
   always @(negedge clk) begin
      if (!rst_a && state_a == 4'd8) begin
         if (nbr < 3) zero_a = zpat[nbr];
         nbr++;
      end
   end

   task automatic wait_a(input logic [3:0] st, input logic [31:0] pcv,
                         input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(state_a == st && pc_a == pcv) && n < 500);
      n_chk++;
      if (!(state_a == st && pc_a == pcv)) begin
         n_fail++;
         $display("FAIL %s: timeout, got state %0d pc %h expected state %0d pc %h",
                  name, state_a, pc_a, st, pcv);
      end
   endtask

   task automatic wait_drain(input int id, input string name);
      int n = 0;
      int qs;
      do begin
         @(negedge clk);
         n++;
         qs = (id == 0) ? q_a.size() : q_b.size();
      end while (qs != 0 && n < 500);
      check(name, qs, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) imem_a[i] = 32'hFC00_0000;
      for (int i = 0; i < 64; i++) imem_b[i] = 32'hFC00_0000;
      imem_a[0]  = 32'h8C02_0004;
      imem_a[1]  = 32'hAC02_0008;
      imem_a[2]  = 32'h2001_0005;
      imem_a[3]  = 32'h0022_1820;
      imem_a[4]  = 32'h1000_0003;
      imem_a[5]  = 32'h0800_0040;
      imem_a[8]  = 32'hFC00_0000;
      imem_a[9]  = 32'h1000_FFFA;
      imem_a[64] = 32'h0800_0040;
      imem_b[16] = 32'h2001_0005;
      imem_b[17] = 32'h0800_0040;
      imem_b[0]  = 32'h0800_003F;
      imem_b[63] = 32'h0022_1820;

      repeat (2) @(negedge clk);
      check("A reset state", {28'h0, state_a}, 32'd0);
      check("A reset pc", pc_a, 32'h0);
      check("A reset ir", ir_a, 32'h0);
      check("A reset retired", retired_a, 32'h0);
      check("A reset illegal", {31'h0, illegal_a}, 32'd0);
      check("A reset mem_req", {31'h0, mem_req_a}, 32'd0);
      check("B reset pc", {24'h0, pc_b}, 32'h40);
      check("B reset state", {28'h0, state_b}, 32'd0);

      push(0, 32'h12340, 32'h04, 1, 1, 0, 0);
      push(0, 32'h01250, 32'h08, 2, 4, 4, 0);
      push(0, 32'h01AB0, 32'h0C, 3, 0, 0, 0);
      push(0, 32'h01670, 32'h10, 4, 0, 0, 0);
      push(0, 32'h00180, 32'h20, 5, 0, 0, 0);
      push(0, 32'h00010, 32'h24, 5, 0, 0, 1);
      push(0, 32'h00180, 32'h10, 6, 0, 0, 0);
      push(0, 32'h00180, 32'h14, 7, 0, 0, 0);
      push(0, 32'h00190, 32'h100, 8, 0, 0, 0);
      push(0, 32'h00190, 32'h100, 9, 0, 0, 0);
      push(1, 32'h00010, 32'h44, 0, 0, 0, 1);
      push(1, 32'h00190, 32'h00, 1, 0, 0, 0);
      push(1, 32'h00190, 32'hFC, 2, 0, 0, 0);
      push(1, 32'h01670, 32'h00, 3, 0, 0, 0);

      #2;
      rst_a = 1'b0;
      rst_b = 1'b0;

      fork
         begin
            wait_a(4'd2, 32'h08, "sw address");
            #2 ready_a = 1'b0;
            repeat (4) @(posedge clk);
            #1 ready_a = 1'b1;
            wait_a(4'd9, 32'h104, "jump at 0x100");
            imem_a[64] = 32'h8C02_0004;
            wait_a(4'd2, 32'h104, "lw address");
            #2 ready_a = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("A queue before reset", q_a.size(), 0);
            check("A retired before reset", retired_a, 32'd9);
            check("A state in MEM_RD wait", {28'h0, state_a}, 32'd3);
            check("A mem_req in MEM_RD wait", {31'h0, mem_req_a}, 32'd1);
            check("A iord in MEM_RD wait", {31'h0, iord_a}, 32'd1);
            #2 rst_a = 1'b1;
            #1;
            check("A mem_req on reset", {31'h0, mem_req_a}, 32'd0);
            check("A iord on reset", {31'h0, iord_a}, 32'd0);
            check("A mem_we on reset", {31'h0, mem_we_a}, 32'd0);
            check("A state on reset", {28'h0, state_a}, 32'd0);
            check("A pc on reset", pc_a, 32'h0);
            check("A ir on reset", ir_a, 32'h0);
            check("A retired on reset", retired_a, 32'h0);
            push(0, 32'h12340, 32'h04, 1, 1, 0, 0);
            push(0, 32'h01250, 32'h08, 2, 1, 1, 0);
            @(negedge clk);
            #2;
            rst_a = 1'b0;
            ready_a = 1'b1;
            wait_drain(0, "A queue drained");
            @(negedge clk);
            #2 rst_a = 1'b1;
         end
         begin
            wait_drain(1, "B queue drained");
            @(negedge clk);
            #2 rst_b = 1'b1;
         end
      join

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter PC_W, default 32: width of the program counter; legal range 8..32.
REQ-002 Parameter RESET_PC, default 0: value loaded into pc on reset; must be a multiple of 4.
REQ-003 Parameter ADDI_EN, default 1: 1 decodes addi (opcode 0x08); 0 treats addi as illegal.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port instr, input, 32: memory read data, sampled as the instruction in FETCH.
REQ-007 Port mem_ready, input, 1: memory completes the current transfer this cycle.
REQ-008 Port alu_zero, input, 1: ALU zero flag, used in BRANCH.
REQ-009 Port mem_req, output, 1: memory transfer request.
REQ-010 Port mem_we, output, 1: write strobe, qualified by mem_req.
REQ-011 Port iord, output, 1: memory address select; 0 = pc, 1 = ALU result.
REQ-012 Port pc, output, PC_W: program counter.
REQ-013 Port ir, output, 32: latched instruction register.
REQ-014 Ports reg_write, reg_dst, mem_to_reg, alu_src_a: outputs, 1 bit each, datapath selects.
REQ-015 Ports alu_src_b and alu_op: outputs, 2 bits each; alu_src_b 0 = rt data, 2 = sign-extended immediate; alu_op 00 = add, 01 = subtract, 10 = funct.
REQ-016 Port state, output, 4: current state encoding, for debug.
REQ-017 Port illegal, output, 1: one-cycle pulse when an unknown opcode is decoded.
REQ-018 Port retired, output, 32: count of completed instructions.

Function
REQ-019 The block SHALL be a Moore FSM; all control outputs SHALL decode from state only. Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
REQ-020 Every control output not listed for a state SHALL be 0 in that state.
REQ-021 FETCH SHALL drive mem_req=1 and iord=0, and hold until mem_ready=1. On that edge: ir<=instr; pc<=pc+4 (modulo 2^PC_W); next state DECODE.
REQ-022 DECODE SHALL branch on ir[31:26]:
- 0x00 -> EXEC
- 0x23 or 0x2B -> MEM_ADDR
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x08 with ADDI_EN=1 -> ADDI_EX
- anything else -> FETCH, with illegal=1 for that DECODE cycle.
REQ-023 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2, alu_op=00; next state MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-024 MEM_RD SHALL drive mem_req=1 and iord=1, and hold until mem_ready; then go to MEM_WB.
REQ-025 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-026 MEM_WR SHALL drive mem_req=1, mem_we=1 and iord=1, and hold until mem_ready; then go to FETCH.
REQ-027 EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_op=10, then go to R_WB. R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-028 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=01. If alu_zero=1: pc<=pc+(sext(ir[15:0])<<2), truncated to PC_W. Next state FETCH.
REQ-029 JUMP SHALL load pc<={pc[PC_W-1:28], ir[25:0], 2'b00}, using the low PC_W bits when PC_W<28; next state FETCH.
REQ-030 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=2, alu_op=00, then go to ADDI_WB. ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-031 retired SHALL increment by 1 (wrapping at 2^32) on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB. It SHALL NOT increment on an illegal DECODE->FETCH transition.
REQ-032 mem_ready SHALL be ignored in states that do not drive mem_req.
REQ-033 Memory wait length is unbounded; no timeout.
REQ-034 ir and pc SHALL change only in the cycles specified in REQ-021, REQ-028 and REQ-029.

Reset
REQ-035 While rst=1, the block SHALL hold: state=FETCH, pc=RESET_PC, ir=0, retired=0, illegal=0.
REQ-036 Reset asserted mid-transfer (MEM_RD, MEM_WR or FETCH wait) SHALL abort it immediately. mem_we SHALL drop asynchronously. mem_req=1 and iord=0 SHALL reappear only through FETCH decode.
REQ-037 After rst deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-038 Reset, then instr=0x8C020004 (lw) with mem_ready=1 every cycle. Required: states 0,1,2,3,4,0; pc=4; retired=1 after 5 cycles.
REQ-039 sw 0xAC020008 with mem_ready held 0 for 3 cycles in MEM_WR. Required: mem_req=mem_we=iord=1 for exactly 4 cycles; state stays 5; then FETCH and retired increments.
REQ-040 beq 0x10000003 fetched at pc=0x10 with alu_zero=1. Required: pc=0x20 after BRANCH. With alu_zero=0: pc=0x14.
REQ-041 j 0x08000040 at pc=0x100 with PC_W=32. Required: pc=0x100 after JUMP. Repeat with PC_W=8: required pc=0x00.
REQ-042 Opcode 0x3F, and addi with ADDI_EN=0. Required: illegal=1 for one cycle; FETCH next; retired unchanged.
REQ-043 rst pulsed during the MEM_RD wait. Required: mem_req drops before the next edge; pc=RESET_PC; retired=0.
